// File: rtl/uart_pkg.sv
// Shared definitions for the host-link UART receiver.
//   rx_state_t           : receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT : 48 MHz / 3 Mbaud
//   DATA_BITS            : payload bits per 8N1 frame
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
//   clk, reset : clock, async active-low reset
//   push, din  : write request and byte (dropped when full unless pop is also set)
//   pop        : advance head (ignored when empty)
//   full/empty : occupancy flags from pointer MSB compare
//   head       : registered head byte; holds its last value while empty
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr, rptr_inc, count;
    logic        do_push, do_pop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count    = wptr - rptr;
    assign rptr_inc = rptr + (AW+1)'(1);

    // A pop frees the slot the concurrent push writes into, so push-while-full
    // succeeds when paired with a pop.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            head <= 8'h00;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr_inc;
            // Head is a register so it can hold its value when empty. The
            // next head comes from memory if it was already stored, or from
            // din when the incoming byte becomes the head this cycle.
            if (do_pop) begin
                if (count > (AW+1)'(1))
                    head <= mem[rptr_inc[AW-1:0]];
                else if (do_push)
                    head <= din;
            end else if (do_push && empty) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a FWFT receive FIFO for the host command link.
//   clk           : system clock (48 MHz)
//   reset         : async active-low reset
//   serial        : raw UART line, idle high, asynchronous to clk
//   data          : byte at FIFO head (valid while data_valid)
//   data_valid    : FIFO non-empty
//   data_strobe   : pop head; ignored while data_valid=0
//   framing_error : one-cycle pulse, stop bit sampled low
//   overflow      : one-cycle pulse, good byte dropped on a full FIFO
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_strobe,
    output logic       framing_error,
    output logic       overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic                 sync1, sync2, rx_s;
    logic [1:0]           settle;
    logic                 armed;
    rx_state_t            state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_idx, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 push, fe;
    logic                 full, empty;

    assign rx_s = sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= serial;
            sync2 <= sync1;
        end
    end

    // The sync flops reset to idle-high, so a line that is already low at
    // reset release must not look like a start bit. settle marks when the
    // sync chain reflects the real pin; armed then requires a real high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            if (settle[1] && rx_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        push      = 1'b0;
        fe        = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (armed && !rx_s)
                    state_nxt = ST_START;
            end
            ST_START: begin
                // Centre of start bit; a high line here was a glitch.
                if (cnt == HALF_M1) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_nxt   = bit_idx + BW'(1);
                    if (bit_idx == BW'(DATA_BITS - 1))
                        state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at stop-bit centre gives half a bit of margin for
                // the next start edge with a one-bit stop.
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        push      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        fe        = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_nxt = '0;
                if (rx_s)
                    state_nxt = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (shreg_nxt),
        .pop   (data_strobe),
        .full  (full),
        .empty (empty),
        .head  (data)
    );

    assign data_valid    = !empty;
    assign framing_error = fe;
    assign overflow      = push && full && !data_strobe;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial = 1'b1;
    logic       data_strobe = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       overflow;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial        (serial),
        .data          (data),
        .data_valid    (data_valid),
        .data_strobe   (data_strobe),
        .framing_error (framing_error),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (overflow)      ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge ending the stop slot.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            serial = fr[j];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, " valid"}, data_valid, 1);
        check({tag, " data"}, data, exp);
        data_strobe = 1'b1;
        @(negedge clk);
        data_strobe = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst data", data, 8'h00);
        check("rst valid", data_valid, 0);
        check("rst fe", framing_error, 0);
        check("rst ov", overflow, 0);
        reset = 1'b1;
        repeat (4 * CPB) @(negedge clk);

        // two good bytes back to back
        send_byte(8'h55, 1'b1);
        send_byte(8'hA3, 1'b1);
        pop_expect("b55", 8'h55);
        pop_expect("bA3", 8'hA3);
        check("t1 empty", data_valid, 0);
        check("t1 fe", fe_cnt, 0);
        check("t1 ov", ov_cnt, 0);

        // short low glitch on idle line
        serial = 1'b0;
        repeat (5) @(negedge clk);
        serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch valid", data_valid, 0);
        check("glitch fe", fe_cnt, 0);

        // framing error followed by long break
        send_byte(8'h7E, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        check("brk fe", fe_cnt, 1);
        serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("brk 7E absent", data_valid, 0);
        send_byte(8'h11, 1'b1);
        pop_expect("b11", 8'h11);
        check("brk empty", data_valid, 0);
        check("brk fe once", fe_cnt, 1);

        // overflow on the 17th byte
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        check("ov none at 16", ov_cnt, 0);
        send_byte(8'h10, 1'b1);
        repeat (2) @(negedge clk);
        check("ov on 17th", ov_cnt, 1);
        for (int i = 0; i < 16; i++) pop_expect("ov order", 8'(i));
        check("ov empty", data_valid, 0);

        // pop exactly on the push cycle with FIFO full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1);
        check("full ov", ov_cnt, 1);
        fork
            send_byte(8'hC4, 1'b1);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                data_strobe = 1'b1;
                @(negedge clk);
                data_strobe = 1'b0;
            end
        join
        check("pp no ov", ov_cnt, 1);
        for (int i = 1; i < 16; i++) pop_expect("pp order", 8'(8'h20 + i));
        pop_expect("pp C4 last", 8'hC4);
        check("pp empty", data_valid, 0);

        // reset during bit 4 of a frame
        send_byte(8'hAA, 1'b1);
        check("pre-rst valid", data_valid, 1);
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (5 * CPB + 8) @(negedge clk);
                reset = 1'b0;
                #1;
                check("mid rst data", data, 8'h00);
                check("mid rst valid", data_valid, 0);
                check("mid rst fe", framing_error, 0);
                check("mid rst ov", overflow, 0);
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        join
        repeat (2 * CPB) @(negedge clk);
        check("post rst empty", data_valid, 0);
        send_byte(8'h3C, 1'b1);
        pop_expect("b3C", 8'h3C);
        check("post rst only 3C", data_valid, 0);
        check("post rst fe", fe_cnt, 1);
        check("post rst ov", ov_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
